// File: rtl/spw_multilink_host_bridge.sv
// rtl/spw_multilink_host_bridge.sv - register-mapped host bridge serving NUM_LINKS SPW_TOP link cores
//
// Purpose: per-link control/status bank, TX FIFO drained into the core write port,
//          RX FIFO filled from the core read port, and time-code tick capture.
// Ports:
//   CLOCK, RESETn                      clock and asynchronous active-low reset
//   avs_address/write/writedata/read   host word-addressed register port (link = addr>>3, reg = addr[2:0])
//   avs_readdata, avs_rdvalid          read data and valid, one cycle after avs_read
//   irq                                interrupt (only with SPW_HB_IRQ_EN)
//   LINK_START, LINK_DISABLE, AUTOSTART, SPILL_ENABLE, TX_CLK_DIV   per-link control levels
//   CURRENTSTATE, FLAGS                per-link status from the cores
//   DATA_I, WR_DATA, TX_FULL           per-link TX write port
//   DATA_O, RD_DATA, RX_EMPTY          per-link RX read port
//   TICK_IN, TIME_IN, TICK_OUT, TIME_OUT  per-link time-code interface
// Optional feature macro: SPW_HB_IRQ_EN (IRQ mask registers and registered irq output)

module spw_multilink_host_bridge #(
  parameter int NUM_LINKS = 2,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16,
  parameter int ADDR_W    = $clog2(NUM_LINKS) + 3
) (
  input  logic                     CLOCK,
  input  logic                     RESETn,
  input  logic [ADDR_W-1:0]        avs_address,
  input  logic                     avs_write,
  input  logic [31:0]              avs_writedata,
  input  logic                     avs_read,
  output logic [31:0]              avs_readdata,
  output logic                     avs_rdvalid,
  output logic                     irq,
  output logic [NUM_LINKS-1:0]     LINK_START,
  output logic [NUM_LINKS-1:0]     LINK_DISABLE,
  output logic [NUM_LINKS-1:0]     AUTOSTART,
  output logic [NUM_LINKS-1:0]     SPILL_ENABLE,
  output logic [7*NUM_LINKS-1:0]   TX_CLK_DIV,
  input  logic [3*NUM_LINKS-1:0]   CURRENTSTATE,
  input  logic [11*NUM_LINKS-1:0]  FLAGS,
  output logic [9*NUM_LINKS-1:0]   DATA_I,
  output logic [NUM_LINKS-1:0]     WR_DATA,
  input  logic [NUM_LINKS-1:0]     TX_FULL,
  input  logic [9*NUM_LINKS-1:0]   DATA_O,
  output logic [NUM_LINKS-1:0]     RD_DATA,
  input  logic [NUM_LINKS-1:0]     RX_EMPTY,
  output logic [NUM_LINKS-1:0]     TICK_IN,
  output logic [8*NUM_LINKS-1:0]   TIME_IN,
  input  logic [NUM_LINKS-1:0]     TICK_OUT,
  input  logic [8*NUM_LINKS-1:0]   TIME_OUT
);

  localparam int TXP_W = $clog2(TX_DEPTH);
  localparam int RXP_W = $clog2(RX_DEPTH);
  localparam logic [TXP_W:0] TX_FULL_LVL = (TXP_W+1)'(TX_DEPTH);
  localparam logic [RXP_W:0] RX_FULL_LVL = (RXP_W+1)'(RX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_WRITE = 2'd1, TX_HOLD = 2'd2} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_REQ = 2'd1, RX_CAP = 2'd2} rx_state_e;

  // Per-link state
  logic [10:0]      ctrl_q      [NUM_LINKS];
  logic [10:0]      ctrl_d      [NUM_LINKS];
  tx_state_e        tx_state_q  [NUM_LINKS];
  tx_state_e        tx_state_d  [NUM_LINKS];
  rx_state_e        rx_state_q  [NUM_LINKS];
  rx_state_e        rx_state_d  [NUM_LINKS];
  logic [TXP_W-1:0] tx_wptr_q   [NUM_LINKS];
  logic [TXP_W-1:0] tx_wptr_d   [NUM_LINKS];
  logic [TXP_W-1:0] tx_rptr_q   [NUM_LINKS];
  logic [TXP_W-1:0] tx_rptr_d   [NUM_LINKS];
  logic [TXP_W:0]   tx_lvl_q    [NUM_LINKS];
  logic [TXP_W:0]   tx_lvl_d    [NUM_LINKS];
  logic [RXP_W-1:0] rx_wptr_q   [NUM_LINKS];
  logic [RXP_W-1:0] rx_wptr_d   [NUM_LINKS];
  logic [RXP_W-1:0] rx_rptr_q   [NUM_LINKS];
  logic [RXP_W-1:0] rx_rptr_d   [NUM_LINKS];
  logic [RXP_W:0]   rx_lvl_q    [NUM_LINKS];
  logic [RXP_W:0]   rx_lvl_d    [NUM_LINKS];
  logic [7:0]       time_in_q   [NUM_LINKS];
  logic [7:0]       time_in_d   [NUM_LINKS];
  logic [7:0]       time_cap_q  [NUM_LINKS];
  logic [7:0]       time_cap_d  [NUM_LINKS];
  logic [NUM_LINKS-1:0] tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
  logic [NUM_LINKS-1:0] tick_seen_q, tick_seen_d, tick_in_q, tick_in_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  // FIFO storage carries no reset; emptiness is defined by the pointers and levels
  logic [8:0] tx_mem [NUM_LINKS][TX_DEPTH];
  logic [8:0] rx_mem [NUM_LINKS][RX_DEPTH];

  // Access decode and FIFO strobes
  logic [NUM_LINKS-1:0] link_hit, ctrl_wr, st_rd, tx_wr, rx_rd, time_wr, mask_wr;
  logic [NUM_LINKS-1:0] tx_push, tx_pop, rx_push, rx_pop;

  function automatic logic [4:0] sat5(input logic [31:0] v);
    return (v > 32'd31) ? 5'd31 : v[4:0];
  endfunction

  always_comb begin
    link_hit = '0; ctrl_wr = '0; st_rd = '0; tx_wr = '0; rx_rd = '0;
    time_wr = '0; mask_wr = '0; tx_push = '0; tx_pop = '0; rx_push = '0; rx_pop = '0;
    for (int l = 0; l < NUM_LINKS; l++) begin
      // Link indices >= NUM_LINKS never match, so those accesses read 0 and writes drop
      link_hit[l] = ((avs_address >> 3) == ADDR_W'(l));
      ctrl_wr[l]  = avs_write && link_hit[l] && (avs_address[2:0] == 3'd0);
      st_rd[l]    = avs_read  && link_hit[l] && (avs_address[2:0] == 3'd1);
      tx_wr[l]    = avs_write && link_hit[l] && (avs_address[2:0] == 3'd2);
      rx_rd[l]    = avs_read  && link_hit[l] && (avs_address[2:0] == 3'd3);
      time_wr[l]  = avs_write && link_hit[l] && (avs_address[2:0] == 3'd4);
      mask_wr[l]  = avs_write && link_hit[l] && (avs_address[2:0] == 3'd5);
      tx_push[l]  = tx_wr[l] && (tx_lvl_q[l] != TX_FULL_LVL);
      tx_pop[l]   = (tx_state_q[l] == TX_WRITE) && (tx_lvl_q[l] != '0);
      rx_push[l]  = (rx_state_q[l] == RX_CAP) && (rx_lvl_q[l] != RX_FULL_LVL);
      rx_pop[l]   = rx_rd[l] && (rx_lvl_q[l] != '0);
    end
  end

`ifdef SPW_HB_IRQ_EN
  logic [2:0] irq_mask_q [NUM_LINKS];
  logic [2:0] irq_mask_d [NUM_LINKS];
  logic       irq_q, irq_d;
`endif

  always_comb begin
    ctrl_d = ctrl_q; tx_state_d = tx_state_q; rx_state_d = rx_state_q;
    tx_wptr_d = tx_wptr_q; tx_rptr_d = tx_rptr_q; tx_lvl_d = tx_lvl_q;
    rx_wptr_d = rx_wptr_q; rx_rptr_d = rx_rptr_q; rx_lvl_d = rx_lvl_q;
    time_in_d = time_in_q; time_cap_d = time_cap_q;
    tx_ovf_d = tx_ovf_q; rx_udf_d = rx_udf_q; tick_seen_d = tick_seen_q;
    tick_in_d = time_wr;
    rd_valid_d = avs_read;
    rd_data_d = '0;
    LINK_START = '0; LINK_DISABLE = '0; AUTOSTART = '0; SPILL_ENABLE = '0;
    TX_CLK_DIV = '0; DATA_I = '0; WR_DATA = '0; RD_DATA = '0; TICK_IN = '0; TIME_IN = '0;
`ifdef SPW_HB_IRQ_EN
    irq_mask_d = irq_mask_q;
    irq_d = 1'b0;
`endif
    for (int l = 0; l < NUM_LINKS; l++) begin
      if (ctrl_wr[l]) ctrl_d[l] = avs_writedata[10:0];
      LINK_START[l]          = ctrl_q[l][0];
      LINK_DISABLE[l]        = ctrl_q[l][1];
      AUTOSTART[l]           = ctrl_q[l][2];
      TX_CLK_DIV[7*l +: 7]   = ctrl_q[l][9:3];
      SPILL_ENABLE[l]        = ctrl_q[l][10];

      // TX FIFO bookkeeping
      if (tx_push[l]) tx_wptr_d[l] = tx_wptr_q[l] + TXP_W'(1);
      if (tx_pop[l])  tx_rptr_d[l] = tx_rptr_q[l] + TXP_W'(1);
      tx_lvl_d[l] = tx_lvl_q[l] + (TXP_W+1)'(tx_push[l]) - (TXP_W+1)'(tx_pop[l]);

      // TX drain: HOLD gives TX_FULL a cycle to reflect the previous write, then
      // chains straight into the next WRITE so the port runs at 1 word / 2 cycles
      case (tx_state_q[l])
        TX_IDLE:  if (tx_lvl_q[l] != '0 && !TX_FULL[l]) tx_state_d[l] = TX_WRITE;
        TX_WRITE: begin
          WR_DATA[l]        = 1'b1;
          DATA_I[9*l +: 9]  = tx_mem[l][tx_rptr_q[l]];
          tx_state_d[l]     = TX_HOLD;
        end
        TX_HOLD:  tx_state_d[l] = (tx_lvl_q[l] != '0 && !TX_FULL[l]) ? TX_WRITE : TX_IDLE;
        default:  tx_state_d[l] = TX_IDLE;
      endcase

      // RX FIFO bookkeeping
      if (rx_push[l]) rx_wptr_d[l] = rx_wptr_q[l] + RXP_W'(1);
      if (rx_pop[l])  rx_rptr_d[l] = rx_rptr_q[l] + RXP_W'(1);
      rx_lvl_d[l] = rx_lvl_q[l] + (RXP_W+1)'(rx_push[l]) - (RXP_W+1)'(rx_pop[l]);

      // RX fill: one read in flight at a time, so a free slot at IDLE is enough
      case (rx_state_q[l])
        RX_IDLE: if (!RX_EMPTY[l] && rx_lvl_q[l] != RX_FULL_LVL) rx_state_d[l] = RX_REQ;
        RX_REQ: begin
          RD_DATA[l]    = 1'b1;
          rx_state_d[l] = RX_CAP;
        end
        RX_CAP:  rx_state_d[l] = RX_IDLE;
        default: rx_state_d[l] = RX_IDLE;
      endcase

      // Sticky bits: a new event in the read-clear cycle wins
      tx_ovf_d[l]    = (tx_wr[l] && tx_lvl_q[l] == TX_FULL_LVL) || (tx_ovf_q[l] && !st_rd[l]);
      rx_udf_d[l]    = (rx_rd[l] && rx_lvl_q[l] == '0) || (rx_udf_q[l] && !st_rd[l]);
      tick_seen_d[l] = TICK_OUT[l] || (tick_seen_q[l] && !st_rd[l]);

      if (time_wr[l])  time_in_d[l]  = avs_writedata[7:0];
      if (TICK_OUT[l]) time_cap_d[l] = TIME_OUT[8*l +: 8];
      TICK_IN[l]         = tick_in_q[l];
      TIME_IN[8*l +: 8]  = time_in_q[l];

`ifdef SPW_HB_IRQ_EN
      if (mask_wr[l]) irq_mask_d[l] = avs_writedata[2:0];
      irq_d = irq_d | (|(irq_mask_q[l] & {tick_seen_q[l], tx_lvl_q[l] == '0, rx_lvl_q[l] != '0}));
`endif

      if (avs_read && link_hit[l]) begin
        case (avs_address[2:0])
          3'd0: rd_data_d = {21'd0, ctrl_q[l]};
          3'd1: rd_data_d = {5'd0, tick_seen_q[l], rx_udf_q[l], tx_ovf_q[l],
                             sat5(32'(rx_lvl_q[l])), sat5(32'(tx_lvl_q[l])),
                             FLAGS[11*l +: 11], CURRENTSTATE[3*l +: 3]};
          3'd3: rd_data_d = (rx_lvl_q[l] == '0) ? 32'h8000_0000 : {23'd0, rx_mem[l][rx_rptr_q[l]]};
          3'd4: rd_data_d = {24'd0, time_cap_q[l]};
`ifdef SPW_HB_IRQ_EN
          3'd5: rd_data_d = {29'd0, irq_mask_q[l]};
`endif
          default: rd_data_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    for (int l = 0; l < NUM_LINKS; l++) begin
      if (tx_push[l]) tx_mem[l][tx_wptr_q[l]] <= avs_writedata[8:0];
      if (rx_push[l]) rx_mem[l][rx_wptr_q[l]] <= DATA_O[9*l +: 9];
    end
  end

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      for (int l = 0; l < NUM_LINKS; l++) begin
        ctrl_q[l]     <= 11'h008;
        tx_state_q[l] <= TX_IDLE;
        rx_state_q[l] <= RX_IDLE;
        tx_wptr_q[l]  <= '0;
        tx_rptr_q[l]  <= '0;
        tx_lvl_q[l]   <= '0;
        rx_wptr_q[l]  <= '0;
        rx_rptr_q[l]  <= '0;
        rx_lvl_q[l]   <= '0;
        time_in_q[l]  <= '0;
        time_cap_q[l] <= '0;
      end
      tx_ovf_q    <= '0;
      rx_udf_q    <= '0;
      tick_seen_q <= '0;
      tick_in_q   <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      tx_state_q  <= tx_state_d;
      rx_state_q  <= rx_state_d;
      tx_wptr_q   <= tx_wptr_d;
      tx_rptr_q   <= tx_rptr_d;
      tx_lvl_q    <= tx_lvl_d;
      rx_wptr_q   <= rx_wptr_d;
      rx_rptr_q   <= rx_rptr_d;
      rx_lvl_q    <= rx_lvl_d;
      time_in_q   <= time_in_d;
      time_cap_q  <= time_cap_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_udf_q    <= rx_udf_d;
      tick_seen_q <= tick_seen_d;
      tick_in_q   <= tick_in_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

`ifdef SPW_HB_IRQ_EN
  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      for (int l = 0; l < NUM_LINKS; l++) irq_mask_q[l] <= '0;
      irq_q <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end
  assign irq = irq_q;
  logic unused_ok;
  assign unused_ok = ^avs_writedata[31:11];
`else
  assign irq = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{avs_writedata[31:11], mask_wr};
`endif

  assign avs_readdata = rd_data_q;
  assign avs_rdvalid  = rd_valid_q;

endmodule
